// File: rtl/mem_bus_responder.sv
// mem_bus_responder
//   Responder end of the 6502C external memory bus. Decodes a RAM window of
//   DEPTH bytes starting at BASE_ADDR. It can stall the CPU with WAIT_STATES
//   RDY-low cycles per access, and it returns read data through a registered
//   data_out/data_oe pair. The top level turns that pair into tristate pins.
//
//   Optional feature: define WRITE_PROTECT_EN to make window offsets
//   >= WP_OFFSET read-only. A blocked write still runs its full wait sequence,
//   leaves RAM unchanged and pulses wp_err for one cycle. Without the macro,
//   wp_err is tied to 0.
//
// Ports
//   phi2      in   1   clock; all state changes on the rising edge
//   RES_n     in   1   asynchronous active-low reset
//   addr      in   16  CPU address bus
//   rw        in   1   1 = read, 0 = write
//   data_in   in   8   CPU write data, valid with addr
//   rdy       out  1   0 = stall the CPU (wait state in progress)
//   data_out  out  8   registered read data
//   data_oe   out  1   1 = drive data_out onto the external data bus
//   sel       out  1   1 while an accepted access is waiting
//   wp_err    out  1   one-cycle pulse on a blocked write
//
// State | meaning
//   S_IDLE | no access pending; accepts a hit on any edge
//   S_WAIT | access latched; cnt counts down the remaining wait states
module mem_bus_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 0,
  parameter int          WP_OFFSET   = 128
) (
  input  logic        phi2,
  input  logic        RES_n,
  input  logic [15:0] addr,
  input  logic        rw,
  input  logic [7:0]  data_in,
  output logic        rdy,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        sel,
  output logic        wp_err
);

  localparam int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] LIMIT = {1'b0, BASE_ADDR} + 17'(DEPTH);
  localparam logic [3:0]  W     = 4'(WAIT_STATES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

`ifdef WRITE_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  logic [0:0]    state;
  logic [3:0]    cnt;
  logic [AW-1:0] lat_off;
  logic          lat_rw;
  logic [7:0]    lat_data;

  logic [7:0]    ram [DEPTH];

  logic          hit;
  logic [AW-1:0] offset;
  logic          done;
  logic [AW-1:0] done_off;
  logic          done_rw;
  logic [7:0]    done_data;
  logic          prot;
  logic          ram_we;

  // The 17-bit compares keep a window that ends at 64K from wrapping.
  assign hit    = ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < LIMIT);
  assign offset = AW'(addr - BASE_ADDR);

  // With no wait states, the access completes on its acceptance edge and uses
  // the live bus values. Otherwise it completes on the WAIT edge that sees
  // cnt==1 and uses the values latched at acceptance.
  always_comb begin
    done      = 1'b0;
    done_off  = lat_off;
    done_rw   = lat_rw;
    done_data = lat_data;
    if (WAIT_STATES == 0) begin
      done      = (state == S_IDLE) && hit;
      done_off  = offset;
      done_rw   = rw;
      done_data = data_in;
    end else begin
      done = (state == S_WAIT) && (cnt == 4'd1);
    end
  end

  assign prot   = WP_EN && ({{(32-AW){1'b0}}, done_off} >= 32'(WP_OFFSET));
  // RES_n gating stops a zero-wait hit from writing RAM while reset is held.
  assign ram_we = RES_n && done && !done_rw && !prot;

  always_ff @(posedge phi2) begin
    if (ram_we) ram[done_off] <= done_data;
  end

  always_ff @(posedge phi2 or negedge RES_n) begin
    if (!RES_n) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      rdy      <= 1'b1;
      sel      <= 1'b0;
      data_out <= 8'h00;
      data_oe  <= 1'b0;
      lat_off  <= '0;
      lat_rw   <= 1'b1;
      lat_data <= 8'h00;
    end else begin
      data_oe <= 1'b0;
      if (done && done_rw) begin
        data_out <= ram[done_off];
        data_oe  <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (hit && (WAIT_STATES != 0)) begin
            state    <= S_WAIT;
            cnt      <= W;
            rdy      <= 1'b0;
            sel      <= 1'b1;
            lat_off  <= offset;
            lat_rw   <= rw;
            lat_data <= data_in;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= S_IDLE;
            rdy   <= 1'b1;
            sel   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef WRITE_PROTECT_EN
  always_ff @(posedge phi2 or negedge RES_n) begin
    if (!RES_n) wp_err <= 1'b0;
    else        wp_err <= done && !done_rw && prot;
  end
`else
  assign wp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder. Four instances share one bus:
//   idx0 W=0, idx1 W=3, idx2 W=4 (base 0000), idx3 W=2 (base FF00, window ends at 64K).
// A transaction-level model predicts every output on every cycle. Each access
// completes W edges after acceptance, and a busy instance ignores the bus.
// Directed literal checks pin the model to hand-computed values.
module tb_mem_bus_responder;
  localparam int NI = 4;
  localparam int          WS [NI] = '{0, 3, 4, 2};
  localparam logic [15:0] BS [NI] = '{16'h0000, 16'h0000, 16'h0000, 16'hFF00};
`ifdef WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif
  localparam logic [15:0] IDLE_A = 16'h8000;

  logic        phi2 = 1'b0;
  logic        RES_n = 1'b1;
  logic [15:0] addr = IDLE_A;
  logic        rw = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic [NI-1:0] rdy, sel, oe, wp;
  logic [7:0]  dout [NI];

  int errors = 0;
  int checks = 0;

  always #5 phi2 = ~phi2;

  mem_bus_responder #(.BASE_ADDR(16'h0000), .DEPTH(256), .WAIT_STATES(0), .WP_OFFSET(128)) u0 (
    .phi2(phi2), .RES_n(RES_n), .addr(addr), .rw(rw), .data_in(data_in),
    .rdy(rdy[0]), .data_out(dout[0]), .data_oe(oe[0]), .sel(sel[0]), .wp_err(wp[0]));
  mem_bus_responder #(.BASE_ADDR(16'h0000), .DEPTH(256), .WAIT_STATES(3), .WP_OFFSET(128)) u1 (
    .phi2(phi2), .RES_n(RES_n), .addr(addr), .rw(rw), .data_in(data_in),
    .rdy(rdy[1]), .data_out(dout[1]), .data_oe(oe[1]), .sel(sel[1]), .wp_err(wp[1]));
  mem_bus_responder #(.BASE_ADDR(16'h0000), .DEPTH(256), .WAIT_STATES(4), .WP_OFFSET(128)) u2 (
    .phi2(phi2), .RES_n(RES_n), .addr(addr), .rw(rw), .data_in(data_in),
    .rdy(rdy[2]), .data_out(dout[2]), .data_oe(oe[2]), .sel(sel[2]), .wp_err(wp[2]));
  mem_bus_responder #(.BASE_ADDR(16'hFF00), .DEPTH(256), .WAIT_STATES(2), .WP_OFFSET(128)) u3 (
    .phi2(phi2), .RES_n(RES_n), .addr(addr), .rw(rw), .data_in(data_in),
    .rdy(rdy[3]), .data_out(dout[3]), .data_oe(oe[3]), .sel(sel[3]), .wp_err(wp[3]));

  // ---------------- reference model ----------------
  bit         busy [NI];
  int         done_at [NI];
  int         p_off [NI];
  bit         p_rw [NI];
  logic [7:0] p_d [NI];
  logic [7:0] mem [NI][256];
  bit         known [NI][256];
  bit         e_rdy [NI], e_sel [NI], e_oe [NI], e_wp [NI], e_dk [NI];
  logic [7:0] e_dout [NI];
  int         cyc = 0;

  function automatic void m_reset();
    for (int k = 0; k < NI; k++) begin
      busy[k] = 1'b0; e_rdy[k] = 1'b1; e_sel[k] = 1'b0; e_oe[k] = 1'b0;
      e_wp[k] = 1'b0; e_dout[k] = 8'h00; e_dk[k] = 1'b1;
    end
  endfunction

  function automatic void m_complete(int k, int off, bit r, logic [7:0] d);
    busy[k] = 1'b0;
    if (r) begin
      e_oe[k] = 1'b1; e_dout[k] = mem[k][off]; e_dk[k] = known[k][off];
    end else if (WP && off >= 128) begin
      e_wp[k] = 1'b1;
    end else begin
      mem[k][off] = d; known[k][off] = 1'b1;
    end
  endfunction

  always @(negedge RES_n) m_reset();

  always @(posedge phi2) begin
    cyc++;
    if (!RES_n) m_reset();
    else begin
      for (int k = 0; k < NI; k++) begin
        int a;
        int off;
        bit h;
        a = int'(addr);
        h = (a >= int'(BS[k])) && (a < int'(BS[k]) + 256);
        off = a - int'(BS[k]);
        e_oe[k] = 1'b0; e_wp[k] = 1'b0;
        if (busy[k]) begin
          if (cyc == done_at[k]) m_complete(k, p_off[k], p_rw[k], p_d[k]);
        end else if (h) begin
          if (WS[k] == 0) m_complete(k, off, rw, data_in);
          else begin
            busy[k] = 1'b1; done_at[k] = cyc + WS[k];
            p_off[k] = off; p_rw[k] = rw; p_d[k] = data_in;
          end
        end
        e_rdy[k] = !busy[k]; e_sel[k] = busy[k];
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  always @(negedge phi2) begin
    for (int k = 0; k < NI; k++) begin
      chk("rdy", k, 8'(rdy[k]), 8'(e_rdy[k]));
      chk("sel", k, 8'(sel[k]), 8'(e_sel[k]));
      chk("data_oe", k, 8'(oe[k]), 8'(e_oe[k]));
      chk("wp_err", k, 8'(wp[k]), 8'(e_wp[k]));
      if (e_dk[k]) chk("data_out", k, dout[k], e_dout[k]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [15:0] a, input logic r, input logic [7:0] d);
    addr = a; rw = r; data_in = d;
    @(posedge phi2);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(IDLE_A, 1'b1, 8'h00);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    #1 RES_n = 1'b0;
    repeat (3) @(posedge phi2);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_rdy", k, 8'(rdy[k]), 8'h01);
      chk("rst_oe", k, 8'(oe[k]), 8'h00);
      chk("rst_sel", k, 8'(sel[k]), 8'h00);
      chk("rst_dout", k, dout[k], 8'h00);
      chk("rst_wp", k, 8'(wp[k]), 8'h00);
    end
    RES_n = 1'b1;

    // fill both windows: low window i -> i^3C, high window i -> ~i
    for (int i = 0; i < 256; i++) begin
      step(16'(i), 1'b0, 8'(i) ^ 8'h3C);
      step(16'hFF00 | 16'(i), 1'b0, ~8'(i));
      idle(4);
    end

    // zero-wait write then read
    step(16'h0010, 1'b0, 8'h5A);
    chk("t1_wr_rdy", 0, 8'(rdy[0]), 8'h01);
    step(16'h0010, 1'b1, 8'h00);
    chk("t1_rd_rdy", 0, 8'(rdy[0]), 8'h01);
    chk("t1_rd_oe", 0, 8'(oe[0]), 8'h01);
    chk("t1_rd_dout", 0, dout[0], 8'h5A);
    idle(1);
    chk("t1_oe_drop", 0, 8'(oe[0]), 8'h00);
    idle(5);

    // three wait states on a read
    step(16'h0020, 1'b0, 8'hC3);
    idle(5);
    step(16'h0020, 1'b1, 8'h00);
    for (int j = 0; j < 3; j++) begin
      chk("t2_rdy_low", 1, 8'(rdy[1]), 8'h00);
      chk("t2_sel_high", 1, 8'(sel[1]), 8'h01);
      if (j < 2) idle(1);
    end
    idle(1);
    chk("t2_rdy_back", 1, 8'(rdy[1]), 8'h01);
    chk("t2_oe", 1, 8'(oe[1]), 8'h01);
    chk("t2_dout", 1, dout[1], 8'hC3);
    idle(1);
    chk("t2_oe_drop", 1, 8'(oe[1]), 8'h00);
    idle(4);

    // miss whose low byte aliases offset 0
    step(16'h0400, 1'b0, 8'hFF);
    chk("t3_miss_rdy", 0, 8'(rdy[0]), 8'h01);
    chk("t3_miss_oe", 0, 8'(oe[0]), 8'h00);
    idle(5);
    step(16'h0000, 1'b1, 8'h00);
    chk("t3_off0", 0, dout[0], 8'h3C);
    chk("t3_oe", 0, 8'(oe[0]), 8'h01);
    idle(5);

    // address change during WAIT is ignored
    step(16'h0030, 1'b0, 8'h11);
    repeat (3) step(16'h0031, 1'b0, 8'h22);
    idle(5);
    step(16'h0030, 1'b1, 8'h00);
    idle(3);
    chk("t4_0030", 1, dout[1], 8'h11);
    chk("t4_oe", 1, 8'(oe[1]), 8'h01);
    idle(4);
    step(16'h0031, 1'b1, 8'h00);
    idle(3);
    chk("t4_0031", 1, dout[1], 8'h0D);
    idle(4);

    // reset abandons a pending write
    step(16'h0040, 1'b0, 8'h12);
    idle(5);
    step(16'h0040, 1'b0, 8'h99);
    idle(1);
    chk("t5_pre_rdy", 2, 8'(rdy[2]), 8'h00);
    #1 RES_n = 1'b0;
    #1;
    chk("t5_rst_rdy", 2, 8'(rdy[2]), 8'h01);
    chk("t5_rst_sel", 2, 8'(sel[2]), 8'h00);
    chk("t5_rst_oe", 2, 8'(oe[2]), 8'h00);
    #1 RES_n = 1'b1;
    idle(2);
    step(16'h0040, 1'b1, 8'h00);
    idle(4);
    chk("t5_readback", 2, dout[2], 8'h12);
    chk("t5_oe", 2, 8'(oe[2]), 8'h01);
    idle(5);

    // write protection at offset 0x80
    step(16'h0080, 1'b0, 8'h00);
    idle(5);
    step(16'h0080, 1'b0, 8'h77);
    chk("t6_wp", 0, 8'(wp[0]), 8'(WP));
    idle(1);
    chk("t6_wp_drop", 0, 8'(wp[0]), 8'h00);
    idle(4);
    step(16'h0080, 1'b1, 8'h00);
    chk("t6_oe", 0, 8'(oe[0]), 8'h01);
`ifndef WRITE_PROTECT_EN
    chk("t6_readback", 0, dout[0], 8'h77);
`endif
    idle(5);

    // randomized traffic with occasional asynchronous reset pulses
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2, 3: a = 16'(($urandom & 32'hFF));
        4, 5:       a = 16'hFF00 | 16'(($urandom & 32'hFF));
        6: begin
          case ($urandom_range(0, 5))
            0: a = 16'h00FF;
            1: a = 16'h0100;
            2: a = 16'hFEFF;
            3: a = 16'hFF00;
            4: a = 16'hFFFF;
            default: a = 16'h0000;
          endcase
        end
        7: a = ($urandom_range(0, 1) == 1) ? 16'h0080 : 16'h007F;
        default: a = 16'($urandom);
      endcase
      step(a, 1'($urandom_range(0, 1)), 8'($urandom));
      if ($urandom_range(0, 199) == 0) begin
        #1 RES_n = 1'b0;
        #2 RES_n = 1'b1;
      end
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
